fetch_unit: RTL

Instruction fetch stage of the ARM core, directly upstream of the controller/decoder. Holds the program counter, issues sequential word fetches to instruction memory over a request/acknowledge interface with in-order responses, buffers returned words in a small prefetch queue, and presents one instruction at a time with a valid/ready handshake. A redirect from the controller (taken branch or PC write) flushes the queue and squashes in-flight responses.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_queue.sv | 60 ++++++
 rtl/fetch_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        addr_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam addr_t PC_STEP  = 32'd4;
    localparam addr_t PC_AHEAD = 32'd8;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries: registered storage, same-cycle push/pop at any occupancy,
// synchronous clear.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    input  logic             clear,
    output fetch_entry_t     head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop & (cnt_q != '0);
    // A pop frees a slot in the same cycle, so a full queue may still accept a push.
    assign do_push = push & ((cnt_q != CNT_W'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_entry;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head       = mem_q[rd_q];
    assign head_valid = (cnt_q != '0);
    assign count      = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, request issue, in-order response tracking with squash, prefetch queue.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect sets sticky FetchFault and halts fetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter addr_t       RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic [31:0] PCPlus8,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        FetchFault
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned DISC_W = 16;

    addr_t              fetch_pc_q, fetch_pc_d;
    addr_t              resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [DISC_W-1:0]  discard_q, discard_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   occ;
    addr_t              redirect_pc;
    logic               redirect_bad;
    logic               xfer;
    logic               push;
    logic               pop;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_pc  = RedirectPC;
    assign redirect_bad = (RedirectPC[1:0] != 2'b00);
`else
    assign redirect_pc  = RedirectPC & ~32'h0000_0003;
    assign redirect_bad = 1'b0;
`endif

    // Queued plus in-flight words never exceed the queue size, so every response has a slot.
    always_comb begin
        imem_req = !reset && !Redirect && !fault_q &&
                   ((CNT_W + 1)'(occ) + (CNT_W + 1)'(inflight_q) < (CNT_W + 1)'(DEPTH));
    end

    assign imem_addr = fetch_pc_q;
    assign xfer      = imem_req & imem_ack;
    assign push      = imem_rvalid & !Redirect & (discard_q == '0);
    assign pop       = InstrValid & InstrReady;

    always_comb begin
        push_entry.pc    = resp_pc_q;
        push_entry.instr = imem_rdata;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        fault_d    = fault_q;
        if (Redirect) begin
            // Everything still outstanding becomes stale; a response this cycle is one of them.
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            inflight_d = '0;
            discard_d  = discard_q + DISC_W'(inflight_q) - DISC_W'(imem_rvalid);
            fault_d    = redirect_bad;
        end else begin
            if (xfer) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            if (imem_rvalid && (discard_q != '0)) begin
                discard_d = discard_q - DISC_W'(1);
            end
            inflight_d = inflight_q + CNT_W'(xfer) - CNT_W'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            fault_q    <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            fault_q    <= fault_d;
        end
    end

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .clear     (Redirect),
        .head      (head),
        .head_valid(InstrValid),
        .count     (occ)
    );

    assign Instr      = head.instr;
    assign InstrPC    = head.pc;
    assign PCPlus8    = head.pc + PC_AHEAD;
    assign FetchFault = fault_q;

endmodule
